bus_rr_arbiter_bcast: RTL and testbench
=======================================

Name: bus_rr_arbiter_bcast

Overview:
Parametrised successor to the shared-bus generator/arbiter: connects DRVRS driver FIFOs over one shared bus, with packets routed by a destination ID in the header. Adds fair round-robin arbitration, per-destination backpressure (full), a programmable broadcast ID, and explicit drop reporting for invalid or self-addressed packets. Sits between the per-driver FWFT FIFOs (pndng/pop/D_pop side) and the per-driver receive FIFOs (push/D_push/full side).

Parameters:
DRVRS, 4, number of driver ports (2..16)
PCKG_SZ, 16, packet width in bits
ID_W, 8, width of the destination ID field, located at D[PCKG_SZ-1 -: ID_W]
BROADCAST, {ID_W{1'b1}}, destination ID meaning "all drivers except the source"
TIMEOUT, 64, DELIVER wait limit in cycles; used only when ARB_TIMEOUT_EN is defined

Ports:
clk  input  1  single clock; all logic on posedge
reset  input  1  synchronous reset, active-high
pndng  input  DRVRS  bit i = driver i FIFO non-empty
pop  output  DRVRS  one-hot pop strobe to driver FIFOs
D_pop  input  DRVRS*PCKG_SZ  FWFT head data; lane i = [i*PCKG_SZ +: PCKG_SZ]
push  output  DRVRS  push strobe(s) to receive FIFOs
D_push  output  DRVRS*PCKG_SZ  delivered packet, replicated on every lane
full  input  DRVRS  bit j = receive FIFO j cannot accept a push
drop_err  output  1  one-cycle pulse when a packet is discarded
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (sync, high): state=IDLE; rr_ptr=0; packet register=0; pop=0, push=0, D_push=0, drop_err=0, busy=0. Reset asserted mid-transfer discards the held packet. No push or pop occurs in the cycle after reset.
- FSM states: IDLE, POP, DELIVER.
- IDLE: if pndng!=0, register grant g = first set bit searching from rr_ptr upward, modulo DRVRS; go to POP. Otherwise stay in IDLE.
- POP (1 cycle): pop[g]=1, decoded combinationally from state. Capture D_pop lane g into the packet register at the same edge; go to DELIVER. Set rr_ptr=(g+1) mod DRVRS.
- DELIVER: decode dest = pkt[PCKG_SZ-1 -: ID_W].
  - If dest==BROADCAST, target mask = all bits except g.
  - Else if dest<DRVRS and dest!=g, target mask = one-hot(dest).
  - Else (dest >= DRVRS and not BROADCAST, or dest == g): drop_err=1 this cycle, no push, go to IDLE.
  - Valid mask: if (mask & full)==0, then push=mask this cycle and go to IDLE. Otherwise push=0 and stay in DELIVER; no partial broadcast delivery.
- D_push: every lane = packet register. Value is held after delivery until the next capture.
- Latency: pndng seen in cycle t -> pop at t+1 -> push (or drop_err) at t+2 if targets not full -> back in IDLE at t+3. Peak throughput is 1 packet per 3 cycles.
- pndng changes during POP or DELIVER are ignored; arbitration happens only in IDLE.
- At most one pop bit is set in any cycle. push is zero outside DELIVER.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: an 8+ bit wait counter clears on entry to DELIVER and increments each stalled cycle. When it reaches TIMEOUT, the packet is dropped: drop_err pulses for 1 cycle, no push, go to IDLE.
- Undefined: DELIVER waits indefinitely on full. No counter logic is present.

Test Plan:
- DRVRS=4, PCKG_SZ=16. Driver 2 pndng with D_pop=16'h01AB -> pop=4'b0100 at t+1; push=4'b0010 at t+2 with all D_push lanes=16'h01AB; busy low at t+3.
- pndng=4'b1111 held, each head addressed to a valid non-self dest -> pop order 0,1,2,3,0, one pop every 3 cycles.
- Driver 1 sends 16'hFF55 -> push=4'b1101 in a single cycle; drop_err=0.
- Packet 16'h0377 from driver 0 with full[3]=1 for 10 cycles -> push=0 for 10 cycles, busy=1; push=4'b1000 in the first cycle full[3]=0.
- Dest 8'h07 from driver 0, and separately dest 8'h02 from driver 2 -> drop_err single-cycle pulse at t+2 with push=0 in both cases.
- reset asserted while in DELIVER -> next cycle push=0, busy=0. Then pndng=4'b1010 -> driver 1 granted first (rr_ptr=0). With ARB_TIMEOUT_EN, TIMEOUT=8 and full held -> drop_err after 8 stall cycles.

Source files
------------

// File: rtl/bus_rr_arbiter_bcast.sv
// Round-robin shared-bus arbiter: pops one driver FIFO at a time and delivers the packet by destination ID
// (unicast, broadcast to all but the source, or dropped). Optional stall timeout: define ARB_TIMEOUT_EN.
module bus_rr_arbiter_bcast #(
    parameter int              DRVRS     = 4,
    parameter int              PCKG_SZ   = 16,
    parameter int              ID_W      = 8,
    parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}},
    parameter int              TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DRVRS-1:0]         pndng,
    output logic [DRVRS-1:0]         pop,
    input  logic [DRVRS*PCKG_SZ-1:0] D_pop,
    output logic [DRVRS-1:0]         push,
    output logic [DRVRS*PCKG_SZ-1:0] D_push,
    input  logic [DRVRS-1:0]         full,
    output logic                     drop_err,
    output logic                     busy
);

    localparam int PTR_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] POP     = 2'd1;
    localparam logic [1:0] DELIVER = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_grant;
    logic [PTR_W-1:0]   w_grant_nxt;
    logic [PTR_W-1:0]   w_ptr_inc;
    logic [PCKG_SZ-1:0] r_pkt;
    logic [PCKG_SZ-1:0] w_head;

    logic [2*DRVRS-1:0] w_pndng_dbl;
    logic [DRVRS-1:0]   w_pndng_rot;
    logic [PTR_W-1:0]   w_ofs;
    logic [PTR_W:0]     w_sum;

    logic [ID_W-1:0]    w_dest;
    logic [DRVRS-1:0]   w_dest_oh;
    logic [DRVRS-1:0]   w_grant_oh;
    logic [DRVRS-1:0]   w_mask;
    logic               w_dest_bcast;
    logic               w_dest_bad;
    logic               w_blocked;
    logic               w_timeout;

    // Rotate requests so bit 0 is the round-robin pointer; the lowest set bit is the winner's offset.
    assign w_pndng_dbl = {pndng, pndng};
    assign w_pndng_rot = DRVRS'(w_pndng_dbl >> r_rr_ptr);

    always_comb begin
        w_ofs = '0;
        for (int k = DRVRS - 1; k >= 0; k--) begin
            if (w_pndng_rot[k]) begin
                w_ofs = PTR_W'(k);
            end
        end
    end

    assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_ofs};
    assign w_grant_nxt = (w_sum >= (PTR_W+1)'(DRVRS)) ? PTR_W'(w_sum - (PTR_W+1)'(DRVRS))
                                                      : PTR_W'(w_sum);
    assign w_ptr_inc   = (r_grant == PTR_W'(DRVRS - 1)) ? '0 : r_grant + 1'b1;

    always_comb begin
        w_head = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (r_grant == PTR_W'(i)) begin
                w_head = D_pop[i*PCKG_SZ +: PCKG_SZ];
            end
        end
    end

    // Destination decode of the held packet.
    assign w_dest       = r_pkt[PCKG_SZ-1 -: ID_W];
    assign w_grant_oh   = DRVRS'(1) << r_grant;
    assign w_dest_bcast = (w_dest == BROADCAST);

    always_comb begin
        w_dest_oh = '0;
        for (int i = 0; i < DRVRS; i++) begin
            w_dest_oh[i] = (w_dest == ID_W'(i));
        end
    end

    assign w_dest_bad = !w_dest_bcast && ((w_dest_oh == '0) || ((w_dest_oh & w_grant_oh) != '0));
    assign w_mask     = w_dest_bcast ? ~w_grant_oh : w_dest_oh;
    assign w_blocked  = (w_mask & full) != '0;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] r_wait;

    assign w_timeout = (r_wait == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= '0;
        end else if (r_state != DELIVER) begin
            r_wait <= '0;
        end else if (w_blocked && !w_dest_bad && !w_timeout) begin
            r_wait <= r_wait + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_timeout        = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        w_state_nxt = r_state;
        push        = '0;
        drop_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (pndng != '0) begin
                    w_state_nxt = POP;
                end
            end
            POP: begin
                w_state_nxt = DELIVER;
            end
            DELIVER: begin
                if (w_dest_bad) begin
                    drop_err    = 1'b1;
                    w_state_nxt = IDLE;
                end else if (!w_blocked) begin
                    push        = w_mask;
                    w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    drop_err    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_pkt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && (pndng != '0)) begin
                r_grant <= w_grant_nxt;
            end
            if (r_state == POP) begin
                r_pkt    <= w_head;
                r_rr_ptr <= w_ptr_inc;
            end
        end
    end

    assign pop    = (r_state == POP) ? w_grant_oh : '0;
    assign D_push = {DRVRS{r_pkt}};
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_bus_rr_arbiter_bcast.sv
// Randomised and directed bench for bus_rr_arbiter_bcast: models driver FIFOs and predicts every
// cycle's pop/push/drop/busy/D_push from the arbitration and routing rules.
module tb_bus_rr_arbiter_bcast;

    localparam int DRVRS   = 4;
    localparam int PCKG_SZ = 16;
    localparam int ID_W    = 8;
    localparam int W       = DRVRS * PCKG_SZ;
    localparam int FDEPTH  = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [DRVRS-1:0] pndng;
    logic [DRVRS-1:0] pop;
    logic [W-1:0]     D_pop;
    logic [DRVRS-1:0] push;
    logic [W-1:0]     D_push;
    logic [DRVRS-1:0] full;
    logic             drop_err;
    logic             busy;

    always #5 clk = ~clk;

    bus_rr_arbiter_bcast #(
        .DRVRS   (DRVRS),
        .PCKG_SZ (PCKG_SZ),
        .ID_W    (ID_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .pop      (pop),
        .D_pop    (D_pop),
        .push     (push),
        .D_push   (D_push),
        .full     (full),
        .drop_err (drop_err),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Driver FIFO model: circular buffers per driver.
    logic [PCKG_SZ-1:0] fmem [DRVRS][FDEPTH];
    int                 fhead [DRVRS];
    int                 fcnt  [DRVRS];

    // Reference model: one transaction in flight, aged in cycles since arbitration.
    bit                 m_active;
    int                 m_age;
    int                 m_g;
    int                 m_ptr;
    logic [PCKG_SZ-1:0] m_pkt;

    int pop_log [$];
    int pop_cyc [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic enqueue(input int d, input logic [PCKG_SZ-1:0] pkt);
        fmem[d][(fhead[d] + fcnt[d]) % FDEPTH] = pkt;
        fcnt[d]++;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < DRVRS; i++) begin
            pndng[i] = (fcnt[i] != 0);
            D_pop[i*PCKG_SZ +: PCKG_SZ] = (fcnt[i] != 0) ? fmem[i][fhead[i]] : '0;
        end
    endtask

    function automatic int pick(input logic [DRVRS-1:0] req, input int ptr);
        int win = -1;
        for (int k = DRVRS - 1; k >= 0; k--) begin
            if (req[(ptr + k) % DRVRS]) win = (ptr + k) % DRVRS;
        end
        return win;
    endfunction

    // Zero mask means the packet must be dropped.
    function automatic logic [DRVRS-1:0] targets(input logic [PCKG_SZ-1:0] pkt, input int src);
        int               dest = int'(pkt[PCKG_SZ-1 -: ID_W]);
        logic [DRVRS-1:0] t    = '0;
        if (dest == 255) begin
            for (int j = 0; j < DRVRS; j++) t[j] = (j != src);
        end else if (dest < DRVRS && dest != src) begin
            t[dest] = 1'b1;
        end
        return t;
    endfunction

    function automatic logic [PCKG_SZ-1:0] rand_pkt();
        int        sel = $urandom_range(0, 9);
        logic [7:0] d;
        if (sel < 6)      d = 8'($urandom_range(0, DRVRS - 1));
        else if (sel < 8) d = 8'hFF;
        else              d = 8'($urandom_range(DRVRS, 254));
        return {d, 8'($urandom)};
    endfunction

    task automatic tick();
        logic [DRVRS-1:0]   popped;
        logic [DRVRS-1:0]   e_pop;
        logic [DRVRS-1:0]   e_push;
        logic [DRVRS-1:0]   tgt;
        logic               e_drop;
        logic               e_busy;
        logic [PCKG_SZ-1:0] next_pkt;
        apply_inputs();
        @(negedge clk);
        cyc++;
        if (reset) begin
            m_active = 1'b0;
            m_ptr    = 0;
            m_pkt    = '0;
        end else begin
            e_pop    = '0;
            e_push   = '0;
            e_drop   = 1'b0;
            e_busy   = m_active;
            next_pkt = m_pkt;
            if (!m_active) begin
                if (pndng != '0) begin
                    m_g      = pick(pndng, m_ptr);
                    m_active = 1'b1;
                    m_age    = 0;
                end
            end else begin
                m_age++;
                if (m_age == 1) begin
                    e_pop    = DRVRS'(1) << m_g;
                    next_pkt = fmem[m_g][fhead[m_g]];
                    m_ptr    = (m_g + 1) % DRVRS;
                end else begin
                    tgt = targets(m_pkt, m_g);
                    if (tgt == '0) begin
                        e_drop   = 1'b1;
                        m_active = 1'b0;
                    end else if ((tgt & full) == '0) begin
                        e_push   = tgt;
                        m_active = 1'b0;
                    end
                end
            end
            check("pop",      64'(pop),      64'(e_pop));
            check("push",     64'(push),     64'(e_push));
            check("drop_err", 64'(drop_err), 64'(e_drop));
            check("busy",     64'(busy),     64'(e_busy));
            check("D_push",   64'(D_push),   64'({DRVRS{m_pkt}}));
            m_pkt = next_pkt;
            for (int i = 0; i < DRVRS; i++) begin
                if (pop[i] === 1'b1) begin
                    pop_log.push_back(i);
                    pop_cyc.push_back(cyc);
                end
            end
        end
        popped = pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < DRVRS; i++) begin
            if (popped[i] === 1'b1 && fcnt[i] > 0) begin
                fhead[i] = (fhead[i] + 1) % FDEPTH;
                fcnt[i]--;
            end
        end
    endtask

    function automatic bit fifos_empty();
        bit e = 1'b1;
        for (int i = 0; i < DRVRS; i++) if (fcnt[i] != 0) e = 1'b0;
        return e;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while ((!fifos_empty() || m_active) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 64'(n < budget), 64'd1);
        tick();
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b1;
        full  = '0;
        pndng = '0;
        D_pop = '0;
        m_active = 1'b0;
        m_age    = 0;
        m_g      = 0;
        m_ptr    = 0;
        m_pkt    = '0;
        for (int i = 0; i < DRVRS; i++) begin
            fhead[i] = 0;
            fcnt[i]  = 0;
        end
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // All drivers pending with valid non-self destinations: pop order 0,1,2,3,0 every 3 cycles.
        pop_log.delete();
        pop_cyc.delete();
        enqueue(0, 16'h0100);
        enqueue(0, 16'h0101);
        enqueue(1, 16'h0211);
        enqueue(2, 16'h0322);
        enqueue(3, 16'h0033);
        drain(60);
        check("order_len", 64'(pop_log.size()), 64'd5);
        for (int k = 0; k < pop_log.size() && k < 5; k++) begin
            check("order", 64'(pop_log[k]), 64'(exp_order[k]));
            if (k > 0) check("spacing", 64'(pop_cyc[k] - pop_cyc[k-1]), 64'd3);
        end

        // Unicast from driver 2 to driver 1.
        enqueue(2, 16'h01AB);
        drain(20);

        // Broadcast from driver 1.
        enqueue(1, 16'hFF55);
        drain(20);

        // Target 3 full for ten stall cycles.
        full = 4'b1000;
        enqueue(0, 16'h0377);
        repeat (12) tick();
        full = '0;
        drain(20);

        // Out-of-range and self-addressed destinations are dropped.
        enqueue(0, 16'h0712);
        drain(20);
        enqueue(2, 16'h0234);
        drain(20);

        // Reset while stalled in DELIVER, then the pointer restarts from 0.
        full = 4'b1000;
        enqueue(2, 16'h0377);
        repeat (4) tick();
        reset = 1'b1;
        full  = '0;
        enqueue(1, 16'h00C1);
        enqueue(3, 16'h02C3);
        pop_log.delete();
        tick();
        reset = 1'b0;
        drain(30);
        check("rst_first_grant", 64'(pop_log.size() > 0 ? pop_log[0] : -1), 64'd1);

        // Random traffic with random backpressure.
        repeat (600) begin
            if ($urandom_range(0, 2) == 0) begin
                int d = $urandom_range(0, DRVRS - 1);
                if (fcnt[d] < 8) enqueue(d, rand_pkt());
            end
            full = ($urandom_range(0, 3) == 0) ? DRVRS'($urandom_range(0, 15)) : '0;
            tick();
        end
        full = '0;
        drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
